pipeline_perf_counter: RTL and testbench



---
 rtl/pipeline_perf_counter.sv | 123 ++++++++++++
 tb/tb_pipeline_perf_counter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_perf_counter.sv
// Pipeline performance monitor: run-cycle and event counters with snapshot/readout and a cycle limit.
// Optional macro PERF_CNT_WRAP_OVF_EN: counters wrap and set a sticky ovf_o instead of saturating.
module pipeline_perf_counter #(
  parameter  int NUM_EVT     = 2,
  parameter  int CNT_W       = 32,
  parameter  int CYCLE_LIMIT = 100,
  localparam int SEL_W       = $clog2(NUM_EVT + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               clear_i,
  input  logic               snap_i,
  input  logic [SEL_W-1:0]   sel_i,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               snap_valid_o,
  output logic               halt_o,
  output logic               ovf_o
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_e;

  // Slot 0 is the cycle counter, slot k is event channel k-1.
  localparam int              NUM_CNT = NUM_EVT + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   live_q   [NUM_CNT];
  logic [CNT_W-1:0]   live_d   [NUM_CNT];
  logic [CNT_W-1:0]   shadow_q [NUM_CNT];
  logic [CNT_W-1:0]   shadow_d [NUM_CNT];
  logic               snap_valid_q, snap_valid_d;
  logic               counting;
  logic               limit_hit;
  logic [NUM_CNT-1:0] hit;
`ifdef PERF_CNT_WRAP_OVF_EN
  logic               wrap;
  logic               ovf_q, ovf_d;
`endif

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    counting = (state_q == RUN) && start_i;
    hit      = {evt_i, 1'b1} & {NUM_CNT{counting}};
`ifdef PERF_CNT_WRAP_OVF_EN
    wrap     = 1'b0;
`endif
    for (int k = 0; k < NUM_CNT; k++) begin
      live_d[k]   = live_q[k];
      shadow_d[k] = snap_i ? live_q[k] : shadow_q[k];
      if (clear_i) begin
        live_d[k] = '0;
      end else if (hit[k]) begin
        if (live_q[k] == CNT_MAX) begin
`ifdef PERF_CNT_WRAP_OVF_EN
          live_d[k] = '0;
          wrap      = 1'b1;
`else
          live_d[k] = live_q[k];
`endif
        end else begin
          live_d[k] = live_q[k] + CNT_W'(1);
        end
      end
    end
    snap_valid_d = snap_i;

    // Halt on the edge whose increment makes the cycle count equal the limit.
    limit_hit = (CYCLE_LIMIT != 0) && counting && !clear_i &&
                (64'(live_d[0]) == 64'(CYCLE_LIMIT));

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN: begin
        if (limit_hit)     state_d = HALTED;
        else if (!start_i) state_d = IDLE;
      end
      HALTED:  if (clear_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      snap_valid_q <= 1'b0;
      // NOTE: shadow registers are reset too, so cnt_o reads 0 before the first snapshot.
      for (int k = 0; k < NUM_CNT; k++) begin
        live_q[k]   <= '0;
        shadow_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      snap_valid_q <= snap_valid_d;
      for (int k = 0; k < NUM_CNT; k++) begin
        live_q[k]   <= live_d[k];
        shadow_q[k] <= shadow_d[k];
      end
    end
  end

`ifdef PERF_CNT_WRAP_OVF_EN
  // Clear on the same edge as a wrap wins, leaving the flag low.
  always_comb ovf_d = clear_i ? 1'b0 : (ovf_q | wrap);

  always_ff @(posedge clk_i) begin
    if (rst_i) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

  assign cnt_o        = (int'(sel_i) < NUM_CNT) ? shadow_q[sel_i] : '0;
  assign snap_valid_o = snap_valid_q;
  assign halt_o       = (state_q == HALTED);

endmodule

// File: tb/tb_pipeline_perf_counter.sv
// Self-checking bench for pipeline_perf_counter: vector table, directed corner sequences and
// randomized traffic against a behavioural model, on a 32-bit/limit-100 and a 4-bit/no-limit instance.
module tb_pipeline_perf_counter;

  logic        clk = 1'b0;
  logic        rst, start, clear, snap;
  logic [1:0]  evt, sel;
  logic [31:0] a_cnt;
  logic [3:0]  b_cnt;
  logic        a_sv, a_halt, a_ovf, b_sv, b_halt, b_ovf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipeline_perf_counter #(.NUM_EVT(2), .CNT_W(32), .CYCLE_LIMIT(100)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .evt_i(evt), .clear_i(clear),
    .snap_i(snap), .sel_i(sel), .cnt_o(a_cnt), .snap_valid_o(a_sv),
    .halt_o(a_halt), .ovf_o(a_ovf));

  pipeline_perf_counter #(.NUM_EVT(2), .CNT_W(4), .CYCLE_LIMIT(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .evt_i(evt), .clear_i(clear),
    .snap_i(snap), .sel_i(sel), .cnt_o(b_cnt), .snap_valid_o(b_sv),
    .halt_o(b_halt), .ovf_o(b_ovf));

  // Behavioural model: index 0 = dut_a, 1 = dut_b; counter slot 0 = cycles, 1..2 = events.
  longint m_live   [2][3];
  longint m_shadow [2][3];
  bit     m_run [2], m_halted [2], m_sv [2], m_ovf [2];

  function automatic int width_of(int m);
    return (m == 0) ? 32 : 4;
  endfunction

  function automatic longint limit_of(int m);
    return (m == 0) ? 100 : 0;
  endfunction

  function automatic void model_step(int m);
    longint maxv = (longint'(1) << width_of(m)) - 1;
    bit     cnt_en;
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        m_live[m][c]   = 0;
        m_shadow[m][c] = 0;
      end
      m_run[m] = 0; m_halted[m] = 0; m_sv[m] = 0; m_ovf[m] = 0;
      return;
    end
    cnt_en  = m_run[m] && start;
    m_sv[m] = snap;
    if (snap)
      for (int c = 0; c < 3; c++) m_shadow[m][c] = m_live[m][c];
    if (clear) begin
      for (int c = 0; c < 3; c++) m_live[m][c] = 0;
      m_ovf[m] = 0;
    end else if (cnt_en) begin
      for (int c = 0; c < 3; c++) begin
        if (c == 0 || evt[c-1]) begin
          if (m_live[m][c] < maxv) begin
            m_live[m][c]++;
          end else begin
`ifdef PERF_CNT_WRAP_OVF_EN
            m_live[m][c] = 0;
            m_ovf[m]     = 1;
`endif
          end
        end
      end
    end
    if (m_halted[m]) begin
      if (clear) m_halted[m] = 0;
    end else if (m_run[m]) begin
      if (cnt_en && !clear && limit_of(m) != 0 && m_live[m][0] == limit_of(m)) begin
        m_run[m]    = 0;
        m_halted[m] = 1;
      end else if (!start) begin
        m_run[m] = 0;
      end
    end else if (start) begin
      m_run[m] = 1;
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic longint model_cnt(int m);
    return (sel <= 2) ? m_shadow[m][sel] : 0;
  endfunction

  // One clock: inputs already driven; advance model with the edge and compare just after it.
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check("a_cnt_model",  a_cnt,  model_cnt(0));
    check("a_sv_model",   a_sv,   m_sv[0]);
    check("a_halt_model", a_halt, m_halted[0]);
    check("a_ovf_model",  a_ovf,  m_ovf[0]);
    check("b_cnt_model",  b_cnt,  model_cnt(1));
    check("b_sv_model",   b_sv,   m_sv[1]);
    check("b_halt_model", b_halt, m_halted[1]);
    check("b_ovf_model",  b_ovf,  m_ovf[1]);
  endtask

  task automatic drive(input logic s, input logic [1:0] e, input logic c, input logic sn,
                       input logic [1:0] sl);
    rst = 1'b0; start = s; evt = e; clear = c; snap = sn; sel = sl;
  endtask

  task automatic do_reset();
    drive(1'b0, 2'b00, 1'b0, 1'b0, 2'b00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Snapshot with start low, then read all three slots of dut_a.
  task automatic snap_read_a(input string tag, input longint e0, input longint e1, input longint e2);
    drive(1'b0, 2'b00, 1'b0, 1'b1, 2'd0); tick();
    check({tag, "_sel0"}, a_cnt, e0);
    check({tag, "_pulse"}, a_sv, 1'b1);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 2'd1); tick();
    check({tag, "_sel1"}, a_cnt, e1);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 2'd2); tick();
    check({tag, "_sel2"}, a_cnt, e2);
  endtask

  typedef struct packed {
    logic        start;
    logic [1:0]  evt;
    logic        clear;
    logic        snap;
    logic [1:0]  sel;
    logic [31:0] exp_cnt;
    logic        exp_sv;
    logic        exp_halt;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int edges;
    bit halted_seen;

    // Basic run: one entry edge, ten counted edges, three ch0 strobes, then snap and readout.
    for (int i = 0; i <= 10; i++)
      tbl[i] = '{start: 1'b1, evt: (i == 1 || i == 4 || i == 7) ? 2'b01 : 2'b00, clear: 1'b0,
                 snap: 1'b0, sel: 2'd0, exp_cnt: 32'd0, exp_sv: 1'b0, exp_halt: 1'b0};
    tbl[11] = '{1'b0, 2'b00, 1'b0, 1'b1, 2'd0, 32'd10, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 2'b00, 1'b0, 1'b0, 2'd1, 32'd3,  1'b0, 1'b0};
    tbl[13] = '{1'b0, 2'b00, 1'b0, 1'b0, 2'd2, 32'd0,  1'b0, 1'b0};
    tbl[14] = '{1'b0, 2'b00, 1'b0, 1'b0, 2'd3, 32'd0,  1'b0, 1'b0};

    do_reset();
    check("reset_cnt",  a_cnt,  0);
    check("reset_sv",   a_sv,   0);
    check("reset_halt", a_halt, 0);
    check("reset_ovf",  a_ovf,  0);

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].start, tbl[i].evt, tbl[i].clear, tbl[i].snap, tbl[i].sel);
      tick();
      check($sformatf("tbl%0d_cnt", i),  a_cnt,  tbl[i].exp_cnt);
      check($sformatf("tbl%0d_sv", i),   a_sv,   tbl[i].exp_sv);
      check($sformatf("tbl%0d_halt", i), a_halt, tbl[i].exp_halt);
    end

    // Cycle limit: halt_o rises on the 101st edge after reset (entry edge + 100 counted).
    do_reset();
    edges = 0;
    halted_seen = 0;
    for (int i = 0; i < 200 && !halted_seen; i++) begin
      drive(1'b1, 2'b10, 1'b0, 1'b0, 2'd0); tick();
      edges++;
      halted_seen = a_halt;
    end
    check("limit_halt_seen", halted_seen, 1'b1);
    check("limit_edge",      edges, 101);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'b11, 1'b0, 1'b0, 2'd0); tick();
    end
    check("limit_halt_stays", a_halt, 1'b1);
    snap_read_a("limit", 100, 0, 100);
    check("limit_halt_ignores_start", a_halt, 1'b1);

    // Pause: 5 counted, 7 idle, re-entry edge, 5 counted.
    do_reset();
    for (int i = 0; i < 6; i++) begin drive(1'b1, 2'b00, 1'b0, 1'b0, 2'd0); tick(); end
    for (int i = 0; i < 7; i++) begin drive(1'b0, 2'b01, 1'b0, 1'b0, 2'd0); tick(); end
    for (int i = 0; i < 6; i++) begin drive(1'b1, 2'b00, 1'b0, 1'b0, 2'd0); tick(); end
    snap_read_a("pause", 10, 0, 0);
    halted_seen = 0;
    for (int i = 0; i < 200 && !halted_seen; i++) begin
      drive(1'b1, 2'b00, 1'b0, 1'b0, 2'd0); tick();
      halted_seen = a_halt;
    end
    check("pause_halt_seen", halted_seen, 1'b1);
    drive(1'b0, 2'b00, 1'b1, 1'b0, 2'd0); tick();
    check("halt_clear_drops", a_halt, 1'b0);
    snap_read_a("after_clear", 0, 0, 0);

    // Snap together with clear: shadow keeps the pre-clear value.
    do_reset();
    for (int i = 0; i < 21; i++) begin drive(1'b1, 2'b00, 1'b0, 1'b0, 2'd0); tick(); end
    drive(1'b0, 2'b00, 1'b1, 1'b1, 2'd0); tick();
    check("snapclr_cnt", a_cnt, 20);
    check("snapclr_sv",  a_sv,  1'b1);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 2'd0); tick();
    check("snapclr_gap_sv", a_sv, 1'b0);
    snap_read_a("snapclr_next", 0, 0, 0);

    // Back-to-back snapshots give back-to-back pulses.
    drive(1'b0, 2'b00, 1'b0, 1'b1, 2'd0); tick();
    check("b2b_sv0", a_sv, 1'b1);
    tick();
    check("b2b_sv1", a_sv, 1'b1);

    // Narrow counters: ch0 held for 20 counted edges on the 4-bit instance.
    do_reset();
    for (int i = 0; i < 21; i++) begin drive(1'b1, 2'b01, 1'b0, 1'b0, 2'd1); tick(); end
    drive(1'b0, 2'b00, 1'b0, 1'b1, 2'd1); tick();
    check("w4_a_evt0", a_cnt, 20);
`ifdef PERF_CNT_WRAP_OVF_EN
    check("w4_b_evt0", b_cnt, 4);
    check("w4_b_ovf",  b_ovf, 1'b1);
`else
    check("w4_b_evt0", b_cnt, 15);
    check("w4_b_ovf",  b_ovf, 1'b0);
`endif
    for (int i = 0; i < 3; i++) begin drive(1'b0, 2'b00, 1'b0, 1'b0, 2'd1); tick(); end
`ifdef PERF_CNT_WRAP_OVF_EN
    check("w4_b_ovf_sticky", b_ovf, 1'b1);
`endif
    drive(1'b0, 2'b00, 1'b1, 1'b0, 2'd1); tick();
    check("w4_b_ovf_cleared", b_ovf, 1'b0);

    // Reset mid-run wipes live, shadow and status; counting needs a fresh start.
    do_reset();
    for (int i = 0; i < 11; i++) begin drive(1'b1, 2'b11, 1'b0, 1'b0, 2'd0); tick(); end
    drive(1'b1, 2'b11, 1'b0, 1'b1, 2'd0); tick();
    check("midrst_pre_cnt", a_cnt, 10);
    drive(1'b1, 2'b11, 1'b1, 1'b1, 2'd1);
    rst = 1'b1; tick();
    check("midrst_cnt",  a_cnt,  0);
    check("midrst_sv",   a_sv,   0);
    check("midrst_halt", a_halt, 0);
    for (int i = 0; i < 3; i++) begin drive(1'b0, 2'b11, 1'b0, 1'b0, 2'd0); tick(); end
    snap_read_a("midrst_idle", 0, 0, 0);
    for (int i = 0; i < 4; i++) begin drive(1'b1, 2'b01, 1'b0, 1'b0, 2'd0); tick(); end
    snap_read_a("midrst_resume", 3, 3, 0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 29) == 0,
            $urandom_range(0, 4) == 0, 2'($urandom_range(0, 3)));
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
